// File: rtl/arya_regfile_pkg.sv
// Shared types and constants for the multithreaded register file.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
package arya_regfile_pkg;

  typedef enum logic [1:0] {
    INIT_ALL = 2'd0,
    IDLE     = 2'd1,
    INIT_CTX = 2'd2
  } seq_state_t;

  localparam logic [63:0] INIT_VALUE_DEFAULT = 64'd0;

  function automatic int flat_idx_w(input int tid_w, input int addr_w);
    return tid_w + addr_w;
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Init sequencer: clears all entries after reset, or one thread context on request.
// Provides the sweep write port and the ready/init_done handshake.
module regfile_init_seq
  import arya_regfile_pkg::*;
#(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int THREAD_ID_WIDTH    = 2,
  localparam int FLAT_W = flat_idx_w(THREAD_ID_WIDTH, REGFILE_ADDR_WIDTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init_req,
  input  logic [THREAD_ID_WIDTH-1:0] init_tid,
  output logic                       ready,
  output logic                       init_done,
  output logic                       sweep_we,
  output logic [FLAT_W-1:0]          sweep_idx
);

  localparam logic [FLAT_W-1:0]             ALL_LAST = {FLAT_W{1'b1}};
  localparam logic [REGFILE_ADDR_WIDTH-1:0] CTX_LAST = {REGFILE_ADDR_WIDTH{1'b1}};

  seq_state_t                 state, state_next;
  logic [FLAT_W-1:0]          cnt, cnt_next;
  logic [THREAD_ID_WIDTH-1:0] tid_lat, tid_lat_next;
  logic                       done_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT_ALL;
      cnt       <= '0;
      tid_lat   <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      tid_lat   <= tid_lat_next;
      init_done <= done_next;
    end
  end

  // The counter halts on its terminal index; a new sweep reloads it from zero.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    tid_lat_next = tid_lat;
    done_next    = 1'b0;
    sweep_we     = 1'b0;
    case (state)
      INIT_ALL: begin
        sweep_we = 1'b1;
        if (cnt == ALL_LAST) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt + FLAT_W'(1);
        end
      end
      IDLE: begin
        if (init_req) begin
          state_next   = INIT_CTX;
          cnt_next     = '0;
          tid_lat_next = init_tid;
        end
      end
      INIT_CTX: begin
        sweep_we = 1'b1;
        if (cnt[REGFILE_ADDR_WIDTH-1:0] == CTX_LAST) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt + FLAT_W'(1);
        end
      end
      default: state_next = INIT_ALL;
    endcase
  end

  assign ready     = (state == IDLE);
  assign sweep_idx = (state == INIT_ALL) ? cnt : {tid_lat, cnt[REGFILE_ADDR_WIDTH-1:0]};

endmodule

// File: rtl/regfile_mt.sv
// Multithreaded register file: one register set per thread, 2 read ports, 1 write port.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to matching read ports.
module regfile_mt
  import arya_regfile_pkg::*;
#(
  parameter int DATAPATH_WIDTH     = 64,
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int THREAD_ID_WIDTH    = 2,
  parameter logic [DATAPATH_WIDTH-1:0] INIT_VALUE = DATAPATH_WIDTH'(INIT_VALUE_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rd_en,
  input  logic [THREAD_ID_WIDTH-1:0]    rd_tid,
  input  logic [REGFILE_ADDR_WIDTH-1:0] r1_addr_in,
  input  logic [REGFILE_ADDR_WIDTH-1:0] r2_addr_in,
  output logic [DATAPATH_WIDTH-1:0]     r1_data_out,
  output logic [DATAPATH_WIDTH-1:0]     r2_data_out,
  output logic                          rd_valid,
  input  logic                          wena,
  input  logic [THREAD_ID_WIDTH-1:0]    wr_tid,
  input  logic [REGFILE_ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [DATAPATH_WIDTH-1:0]     wr_data_in,
  input  logic                          init_req,
  input  logic [THREAD_ID_WIDTH-1:0]    init_tid,
  output logic                          ready,
  output logic                          init_done
);

  localparam int FLAT_W  = flat_idx_w(THREAD_ID_WIDTH, REGFILE_ADDR_WIDTH);
  localparam int ENTRIES = 1 << FLAT_W;

  logic                      sweep_we;
  logic [FLAT_W-1:0]         sweep_idx;
  logic                      host_we;
  logic                      mem_we;
  logic [FLAT_W-1:0]         mem_waddr;
  logic [DATAPATH_WIDTH-1:0] mem_wdata;
  logic [FLAT_W-1:0]         wr_idx, r1_idx, r2_idx;
  logic [DATAPATH_WIDTH-1:0] r1_rd, r2_rd;
  logic [DATAPATH_WIDTH-1:0] r1_data_p1, r2_data_p1;
  logic                      vld_p1;
  logic [DATAPATH_WIDTH-1:0] mem [ENTRIES];

  regfile_init_seq #(
    .REGFILE_ADDR_WIDTH (REGFILE_ADDR_WIDTH),
    .THREAD_ID_WIDTH    (THREAD_ID_WIDTH)
  ) u_init_seq (
    .clk       (clk),
    .reset     (reset),
    .init_req  (init_req),
    .init_tid  (init_tid),
    .ready     (ready),
    .init_done (init_done),
    .sweep_we  (sweep_we),
    .sweep_idx (sweep_idx)
  );

  assign wr_idx  = {wr_tid, wr_addr_in};
  assign r1_idx  = {rd_tid, r1_addr_in};
  assign r2_idx  = {rd_tid, r2_addr_in};
  assign host_we = wena & ready;

  // Sweeps only run while ready is low, so they never collide with host writes.
  always_comb begin
    mem_we    = sweep_we | host_we;
    mem_waddr = wr_idx;
    mem_wdata = wr_data_in;
    if (sweep_we) begin
      mem_waddr = sweep_idx;
      mem_wdata = INIT_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    r1_rd = mem[r1_idx];
    r2_rd = mem[r2_idx];
`ifdef REGFILE_BYPASS_EN
    if (host_we && (wr_idx == r1_idx)) r1_rd = wr_data_in;
    if (host_we && (wr_idx == r2_idx)) r2_rd = wr_data_in;
`endif
  end

  // ---- stage p1: registered read data ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      r1_data_p1 <= '0;
      r2_data_p1 <= '0;
    end else begin
      vld_p1 <= rd_en & ready;
      if (rd_en && ready) begin
        r1_data_p1 <= r1_rd;
        r2_data_p1 <= r2_rd;
      end
    end
  end

  assign r1_data_out = r1_data_p1;
  assign r2_data_out = r2_data_p1;
  assign rd_valid    = vld_p1;

endmodule

// File: tb/tb_regfile_mt.sv
// Directed self-checking bench for regfile_mt (default parameters).
// Expected bypass behaviour follows REGFILE_BYPASS_EN.
module tb_regfile_mt;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en;
  logic [1:0]  rd_tid;
  logic [4:0]  r1_addr_in, r2_addr_in;
  logic [63:0] r1_data_out, r2_data_out;
  logic        rd_valid;
  logic        wena;
  logic [1:0]  wr_tid;
  logic [4:0]  wr_addr_in;
  logic [63:0] wr_data_in;
  logic        init_req;
  logic [1:0]  init_tid;
  logic        ready;
  logic        init_done;

`ifdef REGFILE_BYPASS_EN
  localparam logic [63:0] BYP_EXP = 64'h1234;
`else
  localparam logic [63:0] BYP_EXP = 64'h0;
`endif

  int n_run  = 0;
  int n_fail = 0;

  regfile_mt dut (
    .clk         (clk),
    .reset       (reset),
    .rd_en       (rd_en),
    .rd_tid      (rd_tid),
    .r1_addr_in  (r1_addr_in),
    .r2_addr_in  (r2_addr_in),
    .r1_data_out (r1_data_out),
    .r2_data_out (r2_data_out),
    .rd_valid    (rd_valid),
    .wena        (wena),
    .wr_tid      (wr_tid),
    .wr_addr_in  (wr_addr_in),
    .wr_data_in  (wr_data_in),
    .init_req    (init_req),
    .init_tid    (init_tid),
    .ready       (ready),
    .init_done   (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] t, input logic [4:0] a, input logic [63:0] d);
    wena = 1'b1; wr_tid = t; wr_addr_in = a; wr_data_in = d;
    tick();
    wena = 1'b0;
  endtask

  task automatic rd(input logic [1:0] t, input logic [4:0] a1, input logic [4:0] a2);
    rd_en = 1'b1; rd_tid = t; r1_addr_in = a1; r2_addr_in = a2;
    tick();
    rd_en = 1'b0;
  endtask

  // Counts samples until ready rises (bounded), plus init_done pulses seen on the way.
  task automatic wait_ready(input int limit, output int cycles, output int pulses);
    cycles = 0;
    pulses = 0;
    while (!ready && cycles < limit) begin
      tick();
      cycles++;
      if (init_done) pulses++;
    end
  endtask

  initial begin
    int cyc, pul, vld_seen;
    reset = 1'b1; rd_en = 1'b0; rd_tid = '0; r1_addr_in = '0; r2_addr_in = '0;
    wena = 1'b0; wr_tid = '0; wr_addr_in = '0; wr_data_in = '0;
    init_req = 1'b0; init_tid = '0;
    repeat (3) tick();
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_init_done", {63'd0, init_done}, 64'd0);
    chk("rst_r1", r1_data_out, 64'd0);
    chk("rst_r2", r2_data_out, 64'd0);

    // Power-up sweep of all 128 entries
    reset = 1'b0;
    wait_ready(300, cyc, pul);
    chk("init_all_cycles", 64'(cyc), 64'd128);
    chk("init_all_done", {63'd0, init_done}, 64'd1);
    chk("init_all_pulses", 64'(pul), 64'd1);
    tick();
    chk("init_done_one_cycle", {63'd0, init_done}, 64'd0);
    rd(2'd2, 5'd9, 5'd31);
    chk("post_init_valid", {63'd0, rd_valid}, 64'd1);
    chk("post_init_r1", r1_data_out, 64'd0);
    chk("post_init_r2", r2_data_out, 64'd0);
    tick();
    chk("valid_drops", {63'd0, rd_valid}, 64'd0);

    // Write then read back, checking thread isolation
    wr(2'd1, 5'd5, 64'hDEAD);
    rd(2'd1, 5'd5, 5'd6);
    chk("t1r5_valid", {63'd0, rd_valid}, 64'd1);
    chk("t1r5", r1_data_out, 64'hDEAD);
    chk("t1r6", r2_data_out, 64'd0);
    rd(2'd0, 5'd6, 5'd5);
    chk("t0r5", r2_data_out, 64'd0);

    // Same-cycle write and read of tid 2, r7
    wena = 1'b1; wr_tid = 2'd2; wr_addr_in = 5'd7; wr_data_in = 64'h1234;
    rd_en = 1'b1; rd_tid = 2'd2; r1_addr_in = 5'd7; r2_addr_in = 5'd8;
    tick();
    wena = 1'b0; rd_en = 1'b0;
    chk("byp_r1", r1_data_out, BYP_EXP);
    chk("byp_r2", r2_data_out, 64'd0);
    rd(2'd2, 5'd8, 5'd7);
    chk("after_byp_r2", r2_data_out, 64'h1234);

    // Fill tid 3, plus markers in other threads
    for (int i = 0; i < 32; i++) wr(2'd3, 5'(i), 64'h3000 + 64'(i));
    wr(2'd0, 5'd1, 64'hA0);
    wr(2'd2, 5'd31, 64'hB2);
    rd(2'd3, 5'd0, 5'd31);
    chk("t3_fill_r0", r1_data_out, 64'h3000);
    chk("t3_fill_r31", r2_data_out, 64'h301F);

    // Context clear of tid 3, with a same-cycle write into that context
    init_req = 1'b1; init_tid = 2'd3;
    wena = 1'b1; wr_tid = 2'd3; wr_addr_in = 5'd10; wr_data_in = 64'hFFFF;
    tick();
    init_req = 1'b0;
    chk("ctx_ready_drop", {63'd0, ready}, 64'd0);
    // Traffic while not ready must be ignored
    wr_tid = 2'd0; wr_addr_in = 5'd1; wr_data_in = 64'hBAD;
    rd_en = 1'b1; rd_tid = 2'd0; r1_addr_in = 5'd1; r2_addr_in = 5'd1;
    cyc = 0; pul = 0; vld_seen = 0;
    while (!ready && cyc < 100) begin
      tick();
      cyc++;
      if (init_done) pul++;
      if (rd_valid) vld_seen++;
    end
    wena = 1'b0; rd_en = 1'b0;
    chk("ctx_cycles", 64'(cyc), 64'd32);
    chk("ctx_done", {63'd0, init_done}, 64'd1);
    chk("ctx_pulses", 64'(pul), 64'd1);
    chk("notready_no_valid", 64'(vld_seen), 64'd0);
    rd(2'd3, 5'd0, 5'd31);
    chk("t3_clr_r0", r1_data_out, 64'd0);
    chk("t3_clr_r31", r2_data_out, 64'd0);
    rd(2'd3, 5'd10, 5'd20);
    chk("t3_clr_r10", r1_data_out, 64'd0);
    chk("t3_clr_r20", r2_data_out, 64'd0);
    rd(2'd0, 5'd1, 5'd5);
    chk("t0r1_kept", r1_data_out, 64'hA0);
    rd(2'd1, 5'd5, 5'd0);
    chk("t1r5_kept", r1_data_out, 64'hDEAD);
    rd(2'd2, 5'd31, 5'd7);
    chk("t2r31_kept", r1_data_out, 64'hB2);
    chk("t2r7_kept", r2_data_out, 64'h1234);

    // Reset in the middle of a context clear
    rd(2'd1, 5'd5, 5'd5);
    init_req = 1'b1; init_tid = 2'd2;
    tick();
    init_req = 1'b0;
    repeat (9) tick();
    reset = 1'b1; rd_en = 1'b1;
    tick();
    reset = 1'b0; rd_en = 1'b0;
    chk("midrst_ready", {63'd0, ready}, 64'd0);
    chk("midrst_r1", r1_data_out, 64'd0);
    chk("midrst_valid", {63'd0, rd_valid}, 64'd0);
    wait_ready(300, cyc, pul);
    chk("midrst_cycles", 64'(cyc), 64'd128);
    chk("midrst_pulses", 64'(pul), 64'd1);
    rd(2'd1, 5'd5, 5'd6);
    chk("midrst_t1r5", r1_data_out, 64'd0);
    rd(2'd0, 5'd1, 5'd0);
    chk("midrst_t0r1", r1_data_out, 64'd0);
    rd(2'd2, 5'd31, 5'd7);
    chk("midrst_t2r31", r1_data_out, 64'd0);
    chk("midrst_t2r7", r2_data_out, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mt.md
# regfile_mt

Multithreaded register file for the Arya core pipeline. It holds one architectural register set per hardware thread context, with two synchronous read ports and one write port. A hardware init sequencer clears every entry after reset, and can also clear a single thread context on request. The block sits between decode (read) and writeback (write), and replaces the single-context register file.

## Interface
- DATAPATH_WIDTH, 64, width of each register
- REGFILE_ADDR_WIDTH, 5, register index width; 2**REGFILE_ADDR_WIDTH registers per context
- THREAD_ID_WIDTH, 2, thread id width; 2**THREAD_ID_WIDTH contexts
- INIT_VALUE, 0, value written to each entry by the init sequencer
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rd_en  in  1  read request for both ports
- rd_tid  in  THREAD_ID_WIDTH  thread of both reads
- r1_addr_in, r2_addr_in  in  REGFILE_ADDR_WIDTH  read indices
- r1_data_out, r2_data_out  out  DATAPATH_WIDTH  registered read data
- rd_valid  out  1  read data valid
- wena  in  1  write enable
- wr_tid  in  THREAD_ID_WIDTH  thread of write
- wr_addr_in  in  REGFILE_ADDR_WIDTH  write index
- wr_data_in  in  DATAPATH_WIDTH  write data
- init_req  in  1  request to clear one context
- init_tid  in  THREAD_ID_WIDTH  context to clear
- ready  out  1  block is accepting reads and writes
- init_done  out  1  one-cycle pulse when any sweep completes

## Operation
- Storage: 2**(THREAD_ID_WIDTH+REGFILE_ADDR_WIDTH) entries, flat index {tid, addr}.
- FSM states:
  - INIT_ALL: entered on reset. Writes INIT_VALUE to one entry per cycle, starting at index 0. Goes to IDLE after the last entry.
  - IDLE: normal reads and writes.
  - INIT_CTX: writes INIT_VALUE to entries {init_tid_latched, 0..2**REGFILE_ADDR_WIDTH-1}, one per cycle. Returns to IDLE after the last entry.
- init_req is sampled only in IDLE. On acceptance, init_tid is latched and the FSM enters INIT_CTX. init_req outside IDLE is dropped.
- ready = 1 only in IDLE.
- While ready = 0:
  - wena is ignored.
  - rd_en is ignored, so rd_valid = 0 on the next cycle.
- If wena and init_req are both high in the same IDLE cycle, the write commits first and the sweep starts on the next cycle; the sweep then overwrites that write if it falls in the cleared context.
- Reads: if rd_en and ready, r1_data_out/r2_data_out are loaded with the addressed entries and rd_valid = 1 on the next cycle. Otherwise rd_valid = 0 and the data outputs hold their previous value.
- Write: if wena and ready, the entry {wr_tid, wr_addr_in} takes wr_data_in at the clock edge.

## Timing
- Reset values: r1_data_out = 0, r2_data_out = 0, rd_valid = 0, ready = 0, init_done = 0.
- Sweep counter resets to 0.
- INIT_ALL takes exactly 2**(THREAD_ID_WIDTH+REGFILE_ADDR_WIDTH) cycles after reset deasserts. ready rises on the following cycle, together with the init_done pulse.
- INIT_CTX takes 2**REGFILE_ADDR_WIDTH cycles. ready drops on the cycle after init_req is accepted.
- Read latency is 1 cycle. Write-to-read latency without bypass: 1 cycle; a read in the cycle after the write returns the new data.
- Counter wrap: on reaching its all-ones terminal index, the counter stops and does not wrap.
- Reset asserted mid-sweep or mid-read: the FSM restarts INIT_ALL from index 0, and all outputs return to their reset values.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A same-cycle read and write to the same {tid, addr} while ready returns wr_data_in on that port.
  - Each port is compared independently.
- REGFILE_BYPASS_EN undefined: such a read returns the pre-write value.

## Structure
- Package arya_regfile_pkg contains:
  - FSM state enum {INIT_ALL, IDLE, INIT_CTX}
  - a function computing the flat index width
  - the INIT_VALUE default constant
- Sub-module regfile_init_seq holds the FSM, the sweep counter, the latched tid, and the ready/init_done generation. It outputs the sweep write enable and the sweep index.
- The top level muxes sweep writes against wena, and holds storage, read registers and bypass.

## Test plan
- Defaults, reset for 3 cycles then release → ready stays 0 for 128 cycles, then ready = 1 and init_done pulses once; a read of any {tid, addr} returns 0.
- Write tid 1, r5 = 64'hDEAD, then read tid 1, r5 and tid 0, r5 → 64'hDEAD and 0 respectively, with rd_valid one cycle after rd_en.
- Simultaneous write and read of tid 2, r7 = 64'h1234 → returns 64'h1234 with REGFILE_BYPASS_EN defined, old value 0 without it.
- Fill tid 3 with nonzero data, then init_req with init_tid = 3 → ready low for 32 cycles, init_done pulse; tid 3 reads 0, tid 0–2 unchanged.
- Assert wena and rd_en while ready = 0 → no storage change, rd_valid stays 0.
- Assert reset during INIT_CTX at cycle 10 → a full 128-cycle INIT_ALL restarts and all contexts read 0.
